// File: rtl/image_binarizer_if.sv
// image_binarizer_if: image-buffer read port plus packed-word valid/ready stream
interface image_binarizer_if #(
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 14,
  parameter int PACK_WIDTH  = 8
);
  logic                   readEnable;
  logic [ADDR_WIDTH-1:0]  readAddr;
  logic [PIXEL_WIDTH-1:0] readData;
  logic                   outValid;
  logic                   outReady;
  logic [PACK_WIDTH-1:0]  outData;
  modport master (output readEnable, readAddr, outValid, outData, input readData, outReady);
  modport slave  (input readEnable, readAddr, outValid, outData, output readData, outReady);
endinterface

// File: rtl/image_binarizer.sv
// image_binarizer: thresholds a buffered frame and streams MSB-first packed bits; BINARIZER_WHITE_COUNT_EN adds whiteCount
module image_binarizer #(
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 14,
  parameter int PIXEL_COUNT = 9600,
  parameter int PACK_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  output logic                   busy,
  output logic                   done,
`ifdef BINARIZER_WHITE_COUNT_EN
  output logic [ADDR_WIDTH:0]    whiteCount,
`endif
  image_binarizer_if.master      bus
);
  localparam int CW = $clog2(PACK_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(PIXEL_COUNT - 1);
  localparam logic [ADDR_WIDTH:0] TOTAL    = (ADDR_WIDTH+1)'(PIXEL_COUNT);
  localparam logic [CW-1:0]       LAST_BIT = CW'(PACK_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT, FINISH} state_t;
  state_t                 state, state_nx;
  logic [PIXEL_WIDTH-1:0] thr_reg;
  logic [ADDR_WIDTH:0]    pixel_idx;
  logic [CW-1:0]          bit_cnt;
  logic [PACK_WIDTH-1:0]  pack_reg, shifted;
  logic [ADDR_WIDTH-1:0]  addr_hold;
  logic                   pix_bit, word_end, accept, hs;
  assign pix_bit  = bus.readData >= thr_reg;
  assign word_end = bit_cnt == LAST_BIT || pixel_idx == LAST_IDX;
  assign accept   = state == IDLE && start;
  assign hs       = state == EMIT && bus.outReady;
  assign shifted  = {pack_reg[PACK_WIDTH-2:0], pix_bit};
  assign busy           = state != IDLE;
  assign done           = state == FINISH;
  assign bus.readEnable = state == FETCH;
  assign bus.readAddr   = state == FETCH ? pixel_idx[ADDR_WIDTH-1:0] : addr_hold;
  assign bus.outValid   = state == EMIT;
  assign bus.outData    = pack_reg;
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = LATCH;
      LATCH:   state_nx = word_end ? EMIT : FETCH;
      EMIT:    state_nx = !bus.outReady ? EMIT : pixel_idx == TOTAL ? FINISH : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  // frame datapath: threshold capture, pixel/bit counters and the packing shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      thr_reg   <= '0;
      pixel_idx <= '0;
      bit_cnt   <= '0;
      pack_reg  <= '0;
      addr_hold <= '0;
    end else begin
      if (accept) begin
        thr_reg   <= threshold;
        pixel_idx <= '0;
        bit_cnt   <= '0;
        pack_reg  <= '0;
      end
      if (state == FETCH) addr_hold <= pixel_idx[ADDR_WIDTH-1:0];
      if (state == LATCH) begin
        pack_reg  <= word_end ? shifted << (LAST_BIT - bit_cnt) : shifted;
        pixel_idx <= pixel_idx + 1'b1;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (hs) begin
        bit_cnt  <= '0;
        pack_reg <= '0;
      end
    end
  end
`ifdef BINARIZER_WHITE_COUNT_EN
  // count of pixels at or above the threshold in the current frame
  always_ff @(posedge clock) begin
    if (reset || accept) whiteCount <= '0;
    else if (state == LATCH && pix_bit) whiteCount <= whiteCount + 1'b1;
  end
`endif
endmodule

// File: tb/tb_image_binarizer.sv
// tb_image_binarizer: randomized scoreboard bench for image_binarizer
module tb_image_binarizer;
  localparam int PW = 12, AW = 5, N = 20, K = 8, NW = (N + K - 1) / K;
  logic clock = 0, reset = 1, start = 0;
  logic [PW-1:0] threshold = '0;
  logic busy, done;
`ifdef BINARIZER_WHITE_COUNT_EN
  logic [AW:0] whiteCount;
`endif
  image_binarizer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .PACK_WIDTH(K)) bus ();
  image_binarizer #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .PIXEL_COUNT(N), .PACK_WIDTH(K)) dut (
    .clock(clock), .reset(reset), .start(start), .threshold(threshold),
    .busy(busy), .done(done),
`ifdef BINARIZER_WHITE_COUNT_EN
    .whiteCount(whiteCount),
`endif
    .bus(bus)
  );
  always #5 clock = ~clock;
  logic [PW-1:0] mem [N];
  logic [K-1:0] exp_q [$];
  int exp_white = 0;
  int tests = 0, fails = 0;
  always @(posedge clock) if (bus.readEnable) bus.readData <= mem[bus.readAddr];
  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic push_model(input logic [PW-1:0] thr);
    logic [K-1:0] word;
    logic one;
    exp_white = 0;
    for (int w = 0; w < NW; w++) begin
      word = '0;
      for (int b = 0; b < K; b++) begin
        one = (w * K + b < N) ? (mem[w * K + b] >= thr) : 1'b0;
        word[K-1-b] = one;
        if (one) exp_white++;
      end
      exp_q.push_back(word);
    end
  endtask
  logic stalled = 0;
  logic [K-1:0] held = '0;
  always @(negedge clock) begin
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        check("stall_valid", bus.outValid, 1);
        check("stall_data", bus.outData, held);
        check("stall_read", bus.readEnable, 0);
      end
      if (bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL word: unexpected word %0h with empty scoreboard", bus.outData);
        end else check("word", bus.outData, exp_q.pop_front());
      end
      if (done) begin
        check("done_words_left", exp_q.size(), 0);
`ifdef BINARIZER_WHITE_COUNT_EN
        check("whiteCount", whiteCount, exp_white);
`endif
      end
      stalled = bus.outValid && !bus.outReady;
      held = bus.outData;
    end
  end
  // mode 0: ready high, 1: random ready, 2: 10-cycle stall on first word
  task automatic run_frame(input logic [PW-1:0] thr, input int mode, input bit thr_swap);
    int stall = 0, words = 0;
    bit seen = 0;
    threshold = thr;
    start = 1;
    step();
    start = 0;
    check("accept_busy", busy, 1);
    check("first_read_en", bus.readEnable, 1);
    check("first_addr", bus.readAddr, 0);
    for (int c = 0; c < 2000 && !seen; c++) begin
      start = (c == 5);
      case (mode)
        0: bus.outReady = 1;
        1: bus.outReady = 1'($urandom_range(0, 1));
        default: begin
          if (bus.outValid && stall < 10) begin
            bus.outReady = 0;
            stall++;
          end else bus.outReady = 1;
        end
      endcase
      if (bus.outValid && bus.outReady) words++;
      step();
      if (thr_swap && words >= 1) threshold = '0;
      if (done) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within 2000 cycles");
    end
    start = 1;
    step();
    start = 0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
  endtask
  task automatic ramp();
    for (int i = 0; i < N; i++) mem[i] = PW'(i * 100);
  endtask
  initial begin
    bus.outReady = 0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_en", bus.readEnable, 0);
    check("rst_addr", bus.readAddr, 0);
    check("rst_valid", bus.outValid, 0);
    check("rst_data", bus.outData, 0);
`ifdef BINARIZER_WHITE_COUNT_EN
    check("rst_white", whiteCount, 0);
`endif
    reset = 0;
    step();
    ramp();
    push_model(800);
    run_frame(800, 0, 0);
    for (int i = 0; i < N; i++) mem[i] = 12'hFFF;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF0);
    exp_white = N;
    run_frame(12'hFFF, 0, 0);
    ramp();
    push_model(800);
    run_frame(800, 2, 0);
    push_model(800);
    run_frame(800, 0, 1);
    push_model(800);
    threshold = 800;
    start = 1;
    step();
    start = 0;
    bus.outReady = 1;
    for (int c = 0; c < 200 && !(bus.readEnable && bus.readAddr == 5); c++) step();
    check("reach_pixel5", bus.readAddr, 5);
    step();
    reset = 1;
    step();
    check("abort_valid", bus.outValid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    push_model(800);
    run_frame(800, 1, 0);
    for (int f = 0; f < 8; f++) begin
      logic [PW-1:0] thr;
      for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 4095));
      thr = f == 0 ? 12'd0 : f == 1 ? 12'hFFF : f == 2 ? mem[3] : PW'($urandom_range(0, 4095));
      push_model(thr);
      run_frame(thr, f % 3 == 0 ? 2 : 1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/image_binarizer.md
# image_binarizer

Downstream consumer of the sensor image buffer. After a capture completes, it reads the buffer sequentially through the buffer's 1-cycle-latency read port and compares each pixel against a threshold sampled at start. It packs the resulting 1-bit pixels MSB-first into bytes and streams them through a valid/ready handshake to the host link (UART/SPI framer).

## Interface
Parameters:
- PIXEL_WIDTH, 12: width of a stored pixel.
- ADDR_WIDTH, 14: image buffer address width.
- PIXEL_COUNT, 9600: pixels per frame; must satisfy 1 ≤ PIXEL_COUNT ≤ 2^ADDR_WIDTH.
- PACK_WIDTH, 8: pixels per output word.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- threshold  in  PIXEL_WIDTH  binarization level; sampled on accepted start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final word handshake.
- readEnable  out  1  buffer read strobe.
- readAddr  out  ADDR_WIDTH  buffer read address.
- readData  in  PIXEL_WIDTH  buffer data, valid the cycle after readEnable.
- outValid  out  1  packed word available.
- outReady  in  1  sink accepts the word.
- outData  out  PACK_WIDTH  packed binary pixels, first pixel in the MSB.

## Operation
- States: IDLE, FETCH, LATCH, EMIT, FINISH.
- IDLE:
  - When start is high, latch threshold, clear pixelIdx, bitCnt, packReg, then go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - Drive readEnable=1 and readAddr=pixelIdx.
  - Go to LATCH.
- LATCH:
  - Compute bit = (readData >= thresholdReg), an unsigned compare.
  - packReg <= {packReg[PACK_WIDTH-2:0], bit}.
  - pixelIdx++ and bitCnt++.
  - If bitCnt == PACK_WIDTH-1 or pixelIdx == PIXEL_COUNT-1, go to EMIT. Otherwise go to FETCH.
- EMIT:
  - outValid=1 and outData=packReg. On the final partial word, packReg is first left-shifted so that pad bits are zeros in the LSBs.
  - A handshake occurs when outValid && outReady.
  - On handshake, clear bitCnt and packReg. Go to FINISH if all pixels are consumed, else go to FETCH.
- FINISH: assert done for one cycle, then go to IDLE.
- Word count is ceil(PIXEL_COUNT/PACK_WIDTH). The last word carries PIXEL_COUNT mod PACK_WIDTH valid bits when that is nonzero.
- readAddr holds its last value when not fetching. readEnable is 1 only in FETCH.

## Timing
- Reset values:
  - state = IDLE.
  - busy, done, readEnable, outValid = 0.
  - readAddr, outData = 0.
  - All counters = 0.
- Reset mid-frame aborts immediately:
  - No done pulse.
  - outValid drops the cycle after reset is sampled.
- Latency:
  - start to first FETCH: 1 cycle.
  - Each pixel takes 2 cycles (FETCH+LATCH).
  - A full word reaches outValid 2·PACK_WIDTH cycles after its first FETCH.
- With outReady held high, each word costs 2·PACK_WIDTH+1 cycles.
  - Defaults: 1200 words × 17 = 20400 cycles, plus 1 FINISH cycle.
- Backpressure: while outValid && !outReady, outData and outValid hold stable and no reads are issued.
- outReady is ignored when outValid=0.
- done is high exactly one cycle, in FINISH, after the final handshake cycle. busy falls in the same cycle done falls, i.e. busy is low once back in IDLE.
- A start presented in the cycle done is high is ignored. A start one cycle later is accepted.

## Configuration
- Macro: BINARIZER_WHITE_COUNT_EN.
  - Defined: adds output whiteCount, ADDR_WIDTH+1 bits, reset 0. It clears on accepted start and increments in LATCH when bit=1. Its value is final and stable from done until the next start.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- PIXEL_COUNT=16, buffer = 0,100,…,1500 (step 100), threshold=800, outReady=1.
  - Required: outData 0x00, then 0xFF, then done.
  - whiteCount=8 when the macro is enabled.
- PIXEL_COUNT=20, all pixels 4095, threshold=4095.
  - Required: words 0xFF, 0xFF, 0xF0 (4 zero pad bits); exactly 3 handshakes.
- Backpressure: hold outReady=0 for 10 cycles during the first EMIT.
  - Required: outData stable and readEnable=0 throughout; the stream resumes with the identical sequence.
- Threshold change mid-frame (800→0 after the first word): output is unchanged versus the constant-800 run.
- Assert reset during the LATCH of pixel 5.
  - Required next cycle: IDLE, outValid=0, busy=0, no done.
  - A subsequent start replays the frame from address 0.
- A start pulse while busy is ignored. Back-to-back frames, with start asserted the cycle after done, produce two identical word sequences.
